fp_mult_arbiter: RTL and testbench

- Shares one multi-cycle floating-point multiplier (start/done handshake, IEEE-754 single) between NREQ requesters.
- In the evaluate datapath the requesters are the three products: 0.5*x, x*x and x^2*cos.
- Arbitrates and latches the winner's operands, then issues one multiply and returns the result to the winner with a one-cycle ack.
- Includes a watchdog so a lost multiplier done cannot hang the datapath.

---
 rtl/fp_mult_arbiter.sv | 153 +++++++++++++++
 tb/tb_fp_mult_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// Shares one multi-cycle IEEE-754 multiplier between NREQ requesters.
// Arbitrate, latch operands, issue one start, return result with an ack pulse.
module fp_mult_arbiter #(
  parameter int NREQ      = 3,
  parameter int TIMEOUT   = 64,
  parameter int FIXED_PRI = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_dataa,
  input  logic [NREQ*32-1:0] req_datab,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [31:0]       result,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic              mult_start,
  output logic [31:0]       mult_dataa,
  output logic [31:0]       mult_datab,
  input  logic              mult_done,
  input  logic [31:0]       mult_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [31:0]     result_q, result_d;
  logic            start_q, start_d;
  logic [31:0]     dataa_q, dataa_d;
  logic [31:0]     datab_q, datab_d;
  logic            err_q, err_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;

  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;

  // Round-robin scans upward starting just past the last winner.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (FIXED_PRI != 0) begin
        cand = IW'(k);
      end else begin
        cand = IW'((int'(rr_ptr_q) + 1 + k) % NREQ);
      end
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = '0;
    result_d = result_q;
    start_d  = 1'b0;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    rr_ptr_d = rr_ptr_q;
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = NREQ'(1) << win;
          dataa_d  = req_dataa[32*win +: 32];
          datab_d  = req_datab[32*win +: 32];
          rr_ptr_d = win;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          result_d = mult_result;
          ack_d    = grant_q;
          state_d  = RESP;
        end else if (wd_cnt_q == WW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          result_d = QNAN;
          ack_d    = grant_q;
          state_d  = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      dataa_q  <= '0;
      datab_q  <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= IW'(NREQ - 1);
      wd_cnt_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      start_q  <= start_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign result      = result_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign mult_start  = start_q;
  assign mult_dataa  = dataa_q;
  assign mult_datab  = datab_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: round-robin instance A and
// fixed-priority instance B, each with a latency-programmable multiplier model.
module tb_fp_mult_arbiter;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        err_clr = 1'b0;
  logic [2:0]  req_a = '0, req_b = '0;
  logic [2:0]  rearm_a = '0, rearm_b = '0;
  logic [95:0] dataa = '0, datab = '0;

  logic [2:0]  grant_a, ack_a, grant_b, ack_b;
  logic [31:0] result_a, result_b, ma_a, mb_a, ma_b, mb_b;
  logic        busy_a, busy_b, err_a, err_b, start_a, start_b;
  logic        done_a, done_b;
  logic [31:0] ra = '0, rb = '0;

  int          lat_a = 3;
  int          cnt_a = 0, cnt_b = 0;
  logic        force_a = 1'b0;
  logic [2:0]  last_a = '0, last_b = '0;

  int          n_tests = 0, n_fail = 0;
  int          na_ack = 0, nb_ack = 0;
  exp_t        qa[$], qb[$];
  exp_t        ea, eb;

  always #5 clock = ~clock;

  fp_mult_arbiter #(.NREQ(3), .TIMEOUT(8), .FIXED_PRI(0)) dut_a (
    .clock(clock), .reset(reset), .clk_en(clk_en), .req(req_a),
    .req_dataa(dataa), .req_datab(datab), .grant(grant_a), .ack(ack_a),
    .result(result_a), .busy(busy_a), .timeout_err(err_a), .err_clr(err_clr),
    .mult_start(start_a), .mult_dataa(ma_a), .mult_datab(mb_a),
    .mult_done(done_a), .mult_result(ra)
  );

  fp_mult_arbiter #(.NREQ(3), .TIMEOUT(8), .FIXED_PRI(1)) dut_b (
    .clock(clock), .reset(reset), .clk_en(clk_en), .req(req_b),
    .req_dataa(dataa), .req_datab(datab), .grant(grant_b), .ack(ack_b),
    .result(result_b), .busy(busy_b), .timeout_err(err_b), .err_clr(err_clr),
    .mult_start(start_b), .mult_dataa(ma_b), .mult_datab(mb_b),
    .mult_done(done_b), .mult_result(rb)
  );

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3F000000_40800000: return 32'h40000000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'h40400000_40400000: return 32'h41100000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // lat 0 means the multiplier never answers
  always @(posedge clock) begin
    if (start_a) begin
      cnt_a <= lat_a;
      ra    <= fmul(ma_a, mb_a);
    end else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
    end
    if (start_b) begin
      cnt_b <= 3;
      rb    <= fmul(ma_b, mb_b);
    end else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1;
    end
  end

  assign done_a = (cnt_a == 1) || force_a;
  assign done_b = (cnt_b == 1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    last_a = ack_a & {3{clk_en}};
    last_b = ack_b & {3{clk_en}};
    if (reset && busy_a) chk("grant_a_onehot", 32'($onehot(grant_a)), 32'd1);
    if (reset && busy_b) chk("grant_b_onehot", 32'($onehot(grant_b)), 32'd1);
    if (reset && clk_en && (ack_a != 3'b000)) begin
      na_ack++;
      if (qa.size() == 0) begin
        chk("ack_a_unexpected", 32'(ack_a), 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("ack_a_owner", 32'(ack_a), 32'(1) << ea.idx);
        chk("ack_a_grant", 32'(grant_a), 32'(ack_a));
        chk("result_a", result_a, ea.res);
        chk("err_a_at_ack", 32'(err_a), 32'(ea.err));
      end
    end
    if (reset && clk_en && (ack_b != 3'b000)) begin
      nb_ack++;
      if (qb.size() == 0) begin
        chk("ack_b_unexpected", 32'(ack_b), 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("ack_b_owner", 32'(ack_b), 32'(1) << eb.idx);
        chk("result_b", result_b, eb.res);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (last_a[i]) req_a[i] = rearm_a[i];
      if (last_b[i]) req_b[i] = rearm_b[i];
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    dataa[32*i +: 32] = a;
    datab[32*i +: 32] = b;
  endtask

  task automatic pa(input int i, input logic [31:0] r, input logic e);
    exp_t t;
    t.idx = i; t.res = r; t.err = e;
    qa.push_back(t);
  endtask

  task automatic pb(input int i, input logic [31:0] r);
    exp_t t;
    t.idx = i; t.res = r; t.err = 1'b0;
    qb.push_back(t);
  endtask

  task automatic run_a(input int tgt);
    int k = 0;
    while (na_ack < tgt && k < 300) begin tick(); k++; end
    chk("a_ack_count", 32'(na_ack), 32'(tgt));
  endtask

  task automatic run_b(input int tgt);
    int k = 0;
    while (nb_ack < tgt && k < 300) begin tick(); k++; end
    chk("b_ack_count", 32'(nb_ack), 32'(tgt));
  endtask

  task automatic wait_ack_a(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      if (ack_a != 3'b000) break;
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant_a), 32'd0);
    chk({tag, "_ack"}, 32'(ack_a), 32'd0);
    chk({tag, "_result"}, result_a, 32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_err"}, 32'(err_a), 32'd0);
    chk({tag, "_start"}, 32'(start_a), 32'd0);
    chk({tag, "_dataa"}, ma_a, 32'd0);
    chk({tag, "_datab"}, mb_a, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("rst");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // round-robin, all three requesting
    lat_a = 3;
    set_ops(0, 32'h3F000000, 32'h40800000);
    set_ops(1, 32'h3FC00000, 32'h3FC00000);
    set_ops(2, 32'h40400000, 32'h40400000);
    for (int r = 0; r < 2; r++) begin
      pa(0, 32'h40000000, 1'b0);
      pa(1, 32'h40100000, 1'b0);
      pa(2, 32'h41100000, 1'b0);
    end
    rearm_a = 3'b111;
    req_a   = 3'b111;
    run_a(3);
    rearm_a = 3'b000;
    run_a(6);

    // single requester, latency 5, operand change after grant
    lat_a = 5;
    set_ops(1, 32'h40000000, 32'h40400000);
    pa(1, 32'h40C00000, 1'b0);
    req_a[1] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) set_ops(1, 32'h12345678, 32'h9ABCDEF0);
      @(negedge clock);
      chk("t1_start", 32'(start_a), 32'(k == 1));
      chk("t1_ack", 32'(ack_a), (k == 7) ? 32'd2 : 32'd0);
      chk("t1_grant", 32'(grant_a), (k >= 1 && k <= 7) ? 32'd2 : 32'd0);
      tick();
    end

    // watchdog timeout, then err_clr, then clear colliding with set
    lat_a = 0;
    set_ops(2, 32'h40400000, 32'h40400000);
    pa(2, 32'h7FC00000, 1'b1);
    req_a[2] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clock);
      chk("t4_ack", 32'(ack_a), (k == 10) ? 32'd4 : 32'd0);
      if (k == 9) chk("t4_err_before", 32'(err_a), 32'd0);
      tick();
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clock);
    chk("t4_err_cleared", 32'(err_a), 32'd0);
    tick();
    set_ops(0, 32'h3F000000, 32'h40800000);
    pa(0, 32'h7FC00000, 1'b1);
    req_a[0] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      err_clr = (k == 9);
      @(negedge clock);
      if (k == 9) chk("t4_err_pre2", 32'(err_a), 32'd0);
      if (k == 10) chk("t4_set_wins", 32'(err_a), 32'd1);
      tick();
    end
    err_clr = 1'b0;

    // reset in WAIT, stale done arrives in IDLE
    lat_a = 5;
    set_ops(1, 32'h40000000, 32'h40400000);
    req_a = 3'b010;
    tick();
    tick();
    tick();
    reset = 1'b0;
    req_a = 3'b000;
    @(negedge clock);
    chk("t5_async_busy", 32'(busy_a), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk_reset_vals("t5");
    tick();
    tick();
    @(negedge clock);
    chk("t5_stale_busy", 32'(busy_a), 32'd0);
    chk("t5_stale_ack", 32'(ack_a), 32'd0);
    tick();
    @(negedge clock);
    chk("t5_post_ack", 32'(ack_a), 32'd0);
    chk("t5_post_result", result_a, 32'd0);
    tick();
    lat_a = 3;
    set_ops(0, 32'h3F000000, 32'h40800000);
    set_ops(2, 32'h40400000, 32'h40400000);
    pa(0, 32'h40000000, 1'b0);
    pa(2, 32'h41100000, 1'b0);
    n = na_ack;
    req_a = 3'b101;
    tick();
    @(negedge clock);
    chk("t5_rr_reset_grant", 32'(grant_a), 32'd1);
    run_a(n + 2);

    // clk_en low in WAIT without done: watchdog count frozen
    lat_a = 0;
    pa(0, 32'h7FC00000, 1'b1);
    req_a = 3'b001;
    tick();
    tick();
    clk_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("t6a_busy", 32'(busy_a), 32'd1);
      chk("t6a_ack", 32'(ack_a), 32'd0);
      tick();
    end
    clk_en = 1'b1;
    wait_ack_a(n);
    chk("t6a_latency", 32'(n), 32'd8);
    tick();

    // clk_en low in WAIT with done held high
    set_ops(1, 32'h3FC00000, 32'h3FC00000);
    pa(1, 32'h40100000, 1'b1);
    req_a = 3'b010;
    tick();
    tick();
    clk_en  = 1'b0;
    force_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t6b_ack", 32'(ack_a), 32'd0);
      chk("t6b_result_held", result_a, 32'h7FC00000);
      chk("t6b_grant", 32'(grant_a), 32'd2);
      tick();
    end
    clk_en = 1'b1;
    wait_ack_a(n);
    chk("t6b_latency", 32'(n), 32'd1);
    force_a = 1'b0;
    tick();
    tick();

    // fixed priority: requester 0 starves requester 2
    set_ops(0, 32'h3F000000, 32'h40800000);
    set_ops(2, 32'h40400000, 32'h40400000);
    for (int k = 0; k < 4; k++) pb(0, 32'h40000000);
    pb(2, 32'h41100000);
    rearm_b = 3'b001;
    req_b   = 3'b101;
    run_b(3);
    rearm_b = 3'b000;
    run_b(5);
    tick();

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
